// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / tick generator.
// Each lane owns its counter and double-buffered divisor; the top decodes writes.

module clk_div_lane #(
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             tick,
  output logic             clk_out
);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] cnt, active, shadow;
  logic             wrap;

  assign wrap = (cnt == active - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      active  <= DEF;
      shadow  <= DEF;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      if (wr) shadow <= wr_div;
      // active always takes the pre-write shadow, so a write landing on a
      // wrap/sync/disable only affects the period after that.
      if (!en || sync) begin
        cnt     <= '0;
        tick    <= 1'b0;
        clk_out <= 1'b0;
        active  <= shadow;
      end else if (wrap) begin
        cnt     <= '0;
        tick    <= 1'b1;
        active  <= shadow;
        clk_out <= mode ? 1'b0 : ~clk_out;
      end else begin
        cnt  <= cnt + 1'b1;
        tick <= 1'b0;
        if (mode) clk_out <= 1'b0;
      end
    end
  end
endmodule

module clk_div_multi #(
  parameter int NCH     = 3,
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 5,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   en,
  input  logic [NCH-1:0]   mode,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_div,
  output logic             wr_err,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   clk_out
);
  localparam logic [CH_W:0] NCH_V = (CH_W+1)'(NCH);

  logic           wr_ok;
  logic [NCH-1:0] lane_wr;

  assign wr_ok = wr_en && ({1'b0, wr_ch} < NCH_V) && (wr_div != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_err <= 1'b0;
    else        wr_err <= wr_en && !wr_ok;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    assign lane_wr[i] = wr_ok && (wr_ch == CH_W'(i));

    clk_div_lane #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en[i]),
      .mode    (mode[i]),
      .sync    (sync),
      .wr      (lane_wr[i]),
      .wr_div  (wr_div),
      .tick    (tick[i]),
      .clk_out (clk_out[i])
    );
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: per-cycle expectations are queued
// as stimulus is applied and compared once the clock edge has produced outputs.

module tb_clk_div_multi;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  en = '0, mode = '0;
  logic        sync = 1'b0, wr_en = 1'b0;
  logic [1:0]  wr_ch = '0;
  logic [15:0] wr_div = '0;
  logic        wr_err;
  logic [2:0]  tick, clk_out;

  typedef struct {
    logic [2:0] t;
    logic [2:0] c;
    logic       e;
  } exp_t;

  exp_t sb[$];
  exp_t e, g;
  int   pass_cnt = 0, total = 0;

  clk_div_multi #(.NCH(3), .CNT_W(16), .DEF_DIV(5)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sync(sync),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div), .wr_err(wr_err),
    .tick(tick), .clk_out(clk_out)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = '0; mode = '0; sync = 1'b0;
    wr_en = 1'b0; wr_ch = '0; wr_div = '0;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [15:0] d);
    wr_en = 1'b1; wr_ch = ch; wr_div = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    sb.push_back('{t: 3'b000, c: 3'b000, e: 1'b0});
    g = '{t: tick, c: clk_out, e: wr_err};
    e = sb.pop_front();
    total++;
    if (g !== e) $display("FAIL reset: tick=%b clk_out=%b wr_err=%b want %b %b %b", g.t, g.c, g.e, e.t, e.c, e.e);
    else pass_cnt++;
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    en = 3'b001;
    for (int k = 1; k <= 30; k++) begin
      e = '{t: 3'b000, c: 3'b000, e: 1'b0};
      e.t[0] = (k % 5 == 0);
      e.c[0] = ((k / 5) % 2) == 1;
      sb.push_back(e);
      cyc();
      g = '{t: tick, c: clk_out, e: wr_err};
      e = sb.pop_front();
      total++;
      if (g !== e) $display("FAIL basic k=%0d: tick=%b clk_out=%b wr_err=%b want %b %b %b", k, g.t, g.c, g.e, e.t, e.c, e.e);
      else pass_cnt++;
    end
  endtask

  // Div 3 written at cnt=1 takes effect after the current 5-cycle period;
  // div 4 written on a wrap edge takes effect one wrap later.
  task automatic test_write_mid();
    logic c0;
    do_reset();
    en = 3'b001;
    c0 = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      wr_en  = (k == 2 || k == 14);
      wr_ch  = 2'd0;
      wr_div = (k == 2) ? 16'd3 : 16'd4;
      e = '{t: 3'b000, c: 3'b000, e: 1'b0};
      e.t[0] = (k inside {5, 8, 11, 14, 17, 21, 25});
      if (e.t[0]) c0 = ~c0;
      e.c[0] = c0;
      sb.push_back(e);
      cyc();
      g = '{t: tick, c: clk_out, e: wr_err};
      e = sb.pop_front();
      total++;
      if (g !== e) $display("FAIL write_mid k=%0d: tick=%b clk_out=%b wr_err=%b want %b %b %b", k, g.t, g.c, g.e, e.t, e.c, e.e);
      else pass_cnt++;
    end
    wr_en = 1'b0;
  endtask

  task automatic test_wr_err();
    do_reset();
    en = 3'b001;
    for (int k = 1; k <= 12; k++) begin
      wr_en  = (k == 2 || k == 4);
      wr_ch  = (k == 4) ? 2'd3 : 2'd0;
      wr_div = (k == 4) ? 16'd2 : 16'd0;
      e = '{t: 3'b000, c: 3'b000, e: 1'b0};
      e.e    = (k == 2 || k == 4);
      e.t[0] = (k % 5 == 0);
      e.c[0] = ((k / 5) % 2) == 1;
      sb.push_back(e);
      cyc();
      g = '{t: tick, c: clk_out, e: wr_err};
      e = sb.pop_front();
      total++;
      if (g !== e) $display("FAIL wr_err k=%0d: tick=%b clk_out=%b wr_err=%b want %b %b %b", k, g.t, g.c, g.e, e.t, e.c, e.e);
      else pass_cnt++;
    end
    wr_en = 1'b0;
  endtask

  // Divisors 2/3/5; sync held on edges 8 and 9, channels restart together.
  task automatic test_sync();
    int dv[3] = '{2, 3, 5};
    int base;
    do_reset();
    wr(2'd0, 16'd2);
    wr(2'd1, 16'd3);
    cyc();
    en = 3'b111;
    for (int k = 1; k <= 40; k++) begin
      sync = (k == 8 || k == 9);
      base = (k < 8) ? k : k - 9;
      e = '{t: 3'b000, c: 3'b000, e: 1'b0};
      if (!(k == 8 || k == 9))
        for (int c = 0; c < 3; c++) begin
          e.t[c] = (base % dv[c] == 0);
          e.c[c] = ((base / dv[c]) % 2) == 1;
        end
      sb.push_back(e);
      cyc();
      g = '{t: tick, c: clk_out, e: wr_err};
      e = sb.pop_front();
      total++;
      if (g !== e) $display("FAIL sync k=%0d: tick=%b clk_out=%b wr_err=%b want %b %b %b", k, g.t, g.c, g.e, e.t, e.c, e.e);
      else pass_cnt++;
    end
    sync = 1'b0;
  endtask

  // ch1 (div 5) switches to pulse mode while clk_out is high and back later;
  // ch2 runs with div 1.
  task automatic test_mode();
    do_reset();
    wr(2'd2, 16'd1);
    cyc();
    en = 3'b110;
    for (int k = 1; k <= 25; k++) begin
      mode = (k >= 7 && k <= 16) ? 3'b010 : 3'b000;
      e = '{t: 3'b000, c: 3'b000, e: 1'b0};
      e.t[1] = (k % 5 == 0);
      if (k < 7)       e.c[1] = ((k / 5) % 2) == 1;
      else if (k < 20) e.c[1] = 1'b0;
      else             e.c[1] = (((k - 20) / 5) % 2) == 0;
      e.t[2] = 1'b1;
      e.c[2] = (k % 2) == 1;
      sb.push_back(e);
      cyc();
      g = '{t: tick, c: clk_out, e: wr_err};
      e = sb.pop_front();
      total++;
      if (g !== e) $display("FAIL mode k=%0d: tick=%b clk_out=%b wr_err=%b want %b %b %b", k, g.t, g.c, g.e, e.t, e.c, e.e);
      else pass_cnt++;
    end
    mode = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr(2'd0, 16'd2);
    cyc();
    en = 3'b101;
    for (int k = 1; k <= 3; k++) begin
      e = '{t: 3'b000, c: 3'b000, e: 1'b0};
      e.t[0] = (k % 2 == 0);
      e.c[0] = ((k / 2) % 2) == 1;
      sb.push_back(e);
      cyc();
      g = '{t: tick, c: clk_out, e: wr_err};
      e = sb.pop_front();
      total++;
      if (g !== e) $display("FAIL reset_mid_pre k=%0d: tick=%b clk_out=%b wr_err=%b want %b %b %b", k, g.t, g.c, g.e, e.t, e.c, e.e);
      else pass_cnt++;
    end
    rst_n = 1'b0;
    sb.push_back('{t: 3'b000, c: 3'b000, e: 1'b0});
    #1;
    g = '{t: tick, c: clk_out, e: wr_err};
    e = sb.pop_front();
    total++;
    if (g !== e) $display("FAIL reset_mid_async: tick=%b clk_out=%b wr_err=%b want %b %b %b", g.t, g.c, g.e, e.t, e.c, e.e);
    else pass_cnt++;
    do_reset();
    en = 3'b101;
    for (int k = 1; k <= 12; k++) begin
      e = '{t: 3'b000, c: 3'b000, e: 1'b0};
      e.t[0] = (k % 5 == 0);
      e.c[0] = ((k / 5) % 2) == 1;
      e.t[2] = e.t[0];
      e.c[2] = e.c[0];
      sb.push_back(e);
      cyc();
      g = '{t: tick, c: clk_out, e: wr_err};
      e = sb.pop_front();
      total++;
      if (g !== e) $display("FAIL reset_mid_post k=%0d: tick=%b clk_out=%b wr_err=%b want %b %b %b", k, g.t, g.c, g.e, e.t, e.c, e.e);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_write_mid();
    test_wr_err();
    test_sync();
    test_mode();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
